// File: rtl/sram_arbiter.sv
// Shares one 16-bit asynchronous SRAM between the Z80 bus and a DMA requester.
// CPU has priority; every access is IDLE -> ACCESS (ACC_CYCLES) -> RECOVER.
module sram_arbiter #(
   parameter int ACC_CYCLES = 2
) (
   input  logic        clk_vram,
   input  logic        nreset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_page,
   input  logic [14:0] cpu_a,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_overrun,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [18:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   output logic        busy,
   output logic [17:0] SRAM_ADDR,
   input  logic [15:0] SRAM_DQ_in,
   output logic [15:0] SRAM_DQ_out,
   output logic        SRAM_DQ_oe,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_owner_dma;
   logic          r_we;
   logic          r_lane_ub;
   logic          r_cpu_req_d;
   logic          r_cpu_pending;

   logic          w_cpu_edge;
   logic          w_grant_cpu;
   logic          w_grant_dma;
   logic          w_we;
   logic [18:0]   w_addr;
   logic [7:0]    w_wdata;
   logic [7:0]    w_rbyte;

   assign w_cpu_edge  = cpu_req & ~r_cpu_req_d;
   assign w_grant_cpu = (r_state == S_IDLE) & r_cpu_pending;
   // A CPU edge seen this cycle holds DMA off so the CPU wins a simultaneous request.
   assign w_grant_dma = (r_state == S_IDLE) & ~r_cpu_pending & ~w_cpu_edge & dma_req;

   assign w_we    = w_grant_cpu ? cpu_we : dma_we;
   assign w_addr  = w_grant_cpu ? {cpu_page, cpu_a} : dma_addr;
   assign w_wdata = w_grant_cpu ? cpu_wdata : dma_wdata;
   assign w_rbyte = r_lane_ub ? SRAM_DQ_in[15:8] : SRAM_DQ_in[7:0];
   assign busy    = (r_state != S_IDLE);

   always_ff @(posedge clk_vram or negedge nreset) begin
      if (!nreset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_owner_dma   <= 1'b0;
         r_we          <= 1'b0;
         r_lane_ub     <= 1'b0;
         r_cpu_req_d   <= 1'b0;
         r_cpu_pending <= 1'b0;
         cpu_rdata     <= 8'h00;
         cpu_overrun   <= 1'b0;
         dma_ack       <= 1'b0;
         dma_rdata     <= 8'h00;
         SRAM_ADDR     <= '0;
         SRAM_DQ_out   <= '0;
         SRAM_DQ_oe    <= 1'b0;
         SRAM_CE_N     <= 1'b1;
         SRAM_OE_N     <= 1'b1;
         SRAM_WE_N     <= 1'b1;
         SRAM_UB_N     <= 1'b1;
         SRAM_LB_N     <= 1'b1;
      end else begin
         r_cpu_req_d <= cpu_req;
         dma_ack     <= 1'b0;
         if (w_cpu_edge && r_cpu_pending)
            cpu_overrun <= 1'b1;
         // An edge arriving on the grant cycle merges into the access being granted.
         if (w_grant_cpu)
            r_cpu_pending <= 1'b0;
         else if (w_cpu_edge)
            r_cpu_pending <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_grant_cpu || w_grant_dma) begin
                  r_state     <= S_ACCESS;
                  r_cnt       <= CW'(ACC_CYCLES - 1);
                  r_owner_dma <= ~w_grant_cpu;
                  r_we        <= w_we;
                  r_lane_ub   <= w_addr[0];
                  SRAM_ADDR   <= w_addr[18:1];
                  SRAM_DQ_out <= {w_wdata, w_wdata};
                  SRAM_DQ_oe  <= w_we;
                  SRAM_CE_N   <= 1'b0;
                  SRAM_OE_N   <= w_we;
                  SRAM_WE_N   <= ~w_we;
                  SRAM_UB_N   <= ~w_addr[0];
                  SRAM_LB_N   <= w_addr[0];
               end
            end
            S_ACCESS: begin
               if (r_cnt == '0) begin
                  if (!r_we) begin
                     if (r_owner_dma)
                        dma_rdata <= w_rbyte;
                     else
                        cpu_rdata <= w_rbyte;
                  end
                  SRAM_OE_N <= 1'b1;
                  SRAM_WE_N <= 1'b1;
                  dma_ack   <= r_owner_dma;
                  r_state   <= S_RECOVER;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RECOVER: begin
               SRAM_CE_N  <= 1'b1;
               SRAM_UB_N  <= 1'b1;
               SRAM_LB_N  <= 1'b1;
               SRAM_DQ_oe <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: transaction-level byte-memory model checked
// every cycle, plus hand-computed cycle/data expectations for each scenario.
module tb_sram_arbiter;

   localparam int ACC = 2;

   logic        clk_vram = 1'b0;
   logic        nreset   = 1'b0;
   logic        cpu_req  = 1'b0;
   logic        cpu_we   = 1'b0;
   logic [3:0]  cpu_page = '0;
   logic [14:0] cpu_a    = '0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        cpu_overrun;
   logic        dma_req  = 1'b0;
   logic        dma_we   = 1'b0;
   logic [18:0] dma_addr = '0;
   logic [7:0]  dma_wdata = '0;
   logic        dma_ack;
   logic [7:0]  dma_rdata;
   logic        busy;
   logic [17:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_in;
   logic [15:0] SRAM_DQ_out;
   logic        SRAM_DQ_oe;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

   int n_checks = 0;
   int n_pass   = 0;

   sram_arbiter #(.ACC_CYCLES(ACC)) dut (
      .clk_vram(clk_vram), .nreset(nreset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_page(cpu_page), .cpu_a(cpu_a),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_overrun(cpu_overrun),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata), .busy(busy),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
      .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   always #5 clk_vram = ~clk_vram;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk_vram);
      #1;
   endtask

   function automatic logic [7:0] init_byte(input logic [18:0] ba);
      return ba[7:0] ^ ba[15:8] ^ {5'b0, ba[18:16]} ^ 8'h3C;
   endfunction

   // Word-organised SRAM device.
   logic [15:0] sram_mem [0:262143];
   assign SRAM_DQ_in = sram_mem[SRAM_ADDR];

   always @(posedge clk_vram) begin
      if (!SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_UB_N) sram_mem[SRAM_ADDR][15:8] <= SRAM_DQ_out[15:8];
         if (!SRAM_LB_N) sram_mem[SRAM_ADDR][7:0]  <= SRAM_DQ_out[7:0];
      end
   end

   // Expected contents as a flat byte memory.
   logic [7:0] mem_exp [logic [18:0]];

   function automatic logic [7:0] exp_byte(input logic [18:0] ba);
      if (mem_exp.exists(ba)) return mem_exp[ba];
      return init_byte(ba);
   endfunction

   initial begin
      for (int w = 0; w < 262144; w++)
         sram_mem[w] = {init_byte({18'(w), 1'b1}), init_byte({18'(w), 1'b0})};
      sram_mem[18'h00040] = 16'hBEEF;
      mem_exp[19'h00080] = 8'hEF;
      mem_exp[19'h00081] = 8'hBE;
   end

   // Model: ph = cycles since grant (0 = idle, 1..ACC strobe, ACC+1 recovery).
   initial begin
      int          ph;
      logic        m_dma, m_we, m_pend, m_prev, m_ovr, edge_now, g_cpu, g_dma;
      logic [18:0] m_addr;
      logic [7:0]  m_wd, m_crd, m_drd;
      logic [24:0] e_vec, a_vec;
      logic        e_ce, e_oe, e_we, e_ub, e_lb, e_doe, e_busy, e_ack;
      ph = 0; m_dma = 0; m_we = 0; m_pend = 0; m_prev = 0; m_ovr = 0;
      m_addr = '0; m_wd = '0; m_crd = '0; m_drd = '0;
      forever begin
         @(negedge clk_vram);
         if (!nreset) begin
            ph = 0; m_pend = 0; m_prev = 0; m_ovr = 0; m_crd = '0; m_drd = '0;
         end
         e_ce = 1; e_oe = 1; e_we = 1; e_ub = 1; e_lb = 1; e_doe = 0; e_busy = 0; e_ack = 0;
         if (ph != 0) begin
            e_ce = 0; e_busy = 1; e_doe = m_we;
            e_ub = ~m_addr[0]; e_lb = m_addr[0];
            if (ph <= ACC) begin
               e_oe = m_we; e_we = ~m_we;
            end else begin
               e_ack = m_dma;
            end
         end
         e_vec = {e_ce, e_oe, e_we, e_ub, e_lb, e_doe, e_busy, e_ack, m_ovr, m_crd, m_drd};
         a_vec = {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe,
                  busy, dma_ack, cpu_overrun, cpu_rdata, dma_rdata};
         chk("cycle_outputs", 32'(a_vec), 32'(e_vec));
         if (!nreset) begin
            chk("reset_addr", 32'(SRAM_ADDR), 32'h0);
            chk("reset_dq_out", 32'(SRAM_DQ_out), 32'h0);
            continue;
         end
         if (ph != 0) chk("sram_addr", 32'(SRAM_ADDR), 32'(m_addr[18:1]));
         if (ph != 0 && m_we) chk("sram_dq_out", 32'(SRAM_DQ_out), 32'({m_wd, m_wd}));

         edge_now = cpu_req && !m_prev;
         if (edge_now && m_pend) m_ovr = 1;
         if (ph == ACC) begin
            if (m_we) mem_exp[m_addr] = m_wd;
            else if (m_dma) m_drd = exp_byte(m_addr);
            else m_crd = exp_byte(m_addr);
         end
         if (ph == ACC + 1)
            $display("txn %s %s addr=%05h data=%02h", m_dma ? "dma" : "cpu",
                     m_we ? "wr" : "rd", m_addr, m_we ? m_wd : exp_byte(m_addr));
         g_cpu = (ph == 0) && m_pend;
         g_dma = (ph == 0) && !m_pend && !edge_now && dma_req;
         if (g_cpu) begin
            m_dma = 0; m_we = cpu_we; m_addr = {cpu_page, cpu_a}; m_wd = cpu_wdata;
         end else if (g_dma) begin
            m_dma = 1; m_we = dma_we; m_addr = dma_addr; m_wd = dma_wdata;
         end
         m_pend = g_cpu ? 1'b0 : (m_pend | edge_now);
         if (g_cpu || g_dma) ph = 1;
         else if (ph == ACC + 1) ph = 0;
         else if (ph != 0) ph = ph + 1;
         m_prev = cpu_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   acks, we_low, first_ack, ce_fall;
      logic prev_ce, ub_seen;
      logic [17:0] addr_seen;
      logic [7:0]  got;

      // Reset state
      repeat (3) tick();
      chk("reset_cpu_rdata", 32'(cpu_rdata), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_ce_n", 32'(SRAM_CE_N), 32'h1);
      nreset = 1'b1;
      repeat (2) tick();

      // CPU read of byte 0x00081 (UB of word 0x40 = 0xBEEF), edge in cycle 0
      cpu_page = 4'h0; cpu_a = 15'h0081; cpu_we = 1'b0; cpu_req = 1'b1;
      tick();
      chk("cpu_rd_c1_busy", 32'(busy), 32'h0);
      tick();
      chk("cpu_rd_c2_oe_n", 32'(SRAM_OE_N), 32'h0);
      chk("cpu_rd_c2_lanes", 32'({SRAM_UB_N, SRAM_LB_N}), 32'h1);
      chk("cpu_rd_c2_addr", 32'(SRAM_ADDR), 32'h40);
      tick();
      chk("cpu_rd_c3_oe_n", 32'(SRAM_OE_N), 32'h0);
      chk("cpu_rd_c3_rdata", 32'(cpu_rdata), 32'h0);
      tick();
      chk("cpu_rd_c4_oe_n", 32'(SRAM_OE_N), 32'h1);
      chk("cpu_rd_c4_rdata", 32'(cpu_rdata), 32'hBE);
      cpu_req = 1'b0;
      repeat (3) tick();

      // DMA write 0x5A to byte 0x12345, then read it back
      dma_we = 1'b1; dma_addr = 19'h12345; dma_wdata = 8'h5A; dma_req = 1'b1;
      acks = 0; we_low = 0; addr_seen = '0; ub_seen = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (!SRAM_WE_N) begin
            we_low++; addr_seen = SRAM_ADDR; ub_seen = SRAM_UB_N;
         end
         if (dma_ack) begin
            acks++; dma_req = 1'b0;
         end
      end
      chk("dma_wr_acks", 32'(acks), 32'd1);
      chk("dma_wr_we_low", 32'(we_low), 32'd2);
      chk("dma_wr_addr", 32'(addr_seen), 32'h091A2);
      chk("dma_wr_ub_n", 32'(ub_seen), 32'h0);
      dma_we = 1'b0; dma_req = 1'b1; acks = 0; got = '0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (dma_ack) begin
            acks++; got = dma_rdata; dma_req = 1'b0;
         end
      end
      chk("dma_rd_acks", 32'(acks), 32'd1);
      chk("dma_rd_data", 32'(got), 32'h5A);

      // Priority: CPU read 0x08010 and DMA read 0x00081 requested together
      cpu_page = 4'h1; cpu_a = 15'h0010; cpu_req = 1'b1;
      dma_addr = 19'h00081; dma_req = 1'b1;
      first_ack = -1; got = '0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 2) chk("prio_c2_cpu_addr", 32'({SRAM_OE_N, SRAM_ADDR}), 32'h04008);
         if (c == 4) begin
            chk("prio_c4_cpu_rdata", 32'(cpu_rdata), 32'hAC);
            cpu_req = 1'b0;
         end
         if (dma_ack && first_ack < 0) begin
            first_ack = c; got = dma_rdata; dma_req = 1'b0;
         end
      end
      chk("prio_dma_ack_cycle", 32'(first_ack), 32'd8);
      chk("prio_dma_rdata", 32'(got), 32'hBE);
      chk("prio_no_overrun", 32'(cpu_overrun), 32'h0);

      // Worst case: DMA write granted in cycle 0, CPU edge lands during it
      dma_we = 1'b1; dma_addr = 19'h00200; dma_wdata = 8'h33; dma_req = 1'b1;
      cpu_page = 4'h0; cpu_a = 15'h0080; cpu_we = 1'b0;
      first_ack = -1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 1) cpu_req = 1'b1;
         if (dma_ack && first_ack < 0) begin
            first_ack = c; dma_req = 1'b0;
         end
         if (c == 6) chk("worst_c6_rdata_old", 32'(cpu_rdata), 32'hAC);
         if (c == 7) chk("worst_c7_rdata", 32'(cpu_rdata), 32'hEF);
         if (c == 8) cpu_req = 1'b0;
      end
      chk("worst_dma_ack_cycle", 32'(first_ack), 32'd3);

      // Overrun: two CPU edges while the first waits behind a DMA read
      dma_we = 1'b0; dma_addr = 19'h12345; dma_req = 1'b1;
      cpu_a = 15'h0081;
      ce_fall = 0; prev_ce = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 1) cpu_req = 1'b1;
         if (c == 2) cpu_req = 1'b0;
         if (c == 3) cpu_req = 1'b1;
         if (c == 8) cpu_req = 1'b0;
         if (dma_ack) dma_req = 1'b0;
         if (prev_ce && !SRAM_CE_N) ce_fall++;
         prev_ce = SRAM_CE_N;
      end
      chk("ovr_flag", 32'(cpu_overrun), 32'h1);
      chk("ovr_accesses", 32'(ce_fall), 32'd2);
      chk("ovr_cpu_rdata", 32'(cpu_rdata), 32'hBE);
      chk("ovr_dma_rdata", 32'(dma_rdata), 32'h5A);
      repeat (4) tick();
      chk("ovr_sticky", 32'(cpu_overrun), 32'h1);

      // Reset asserted while WE_N is low
      dma_we = 1'b1; dma_addr = 19'h00300; dma_wdata = 8'h77; dma_req = 1'b1;
      we_low = 0;
      for (int c = 1; c <= 10 && we_low == 0; c++) begin
         tick();
         if (!SRAM_WE_N) we_low = 1;
      end
      chk("rst_saw_write", 32'(we_low), 32'd1);
      #2 nreset = 1'b0;
      #1;
      chk("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
      chk("rst_dq_oe", 32'(SRAM_DQ_oe), 32'h0);
      chk("rst_overrun", 32'(cpu_overrun), 32'h0);
      dma_req = 1'b0;
      acks = 0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (dma_ack) acks++;
      end
      nreset = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (dma_ack) acks++;
      end
      chk("rst_no_ack", 32'(acks), 32'd0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the external 16-bit asynchronous SRAM between the Z80 bus and a DMA requester (snapshot/tape loader). It sits between the CPU address/data bus decode and the SRAM pins, and runs on the fast video-RAM clock. It sequences every SRAM cycle: address setup, strobe, latch and recovery. The CPU always has priority; DMA uses idle slots.

## Interface
- ACC_CYCLES, 2, number of cycles OE_N/WE_N are held low per access (>=1)

- clk_vram  in  1  fast system clock; all CPU-side inputs are synchronous to it
- nreset  in  1  asynchronous, active-low reset
- cpu_req  in  1  level; high while the CPU runs a memory cycle to the SRAM window; rising edge starts one access
- cpu_we  in  1  1 = write, sampled at grant
- cpu_page  in  4  upper byte-address bits
- cpu_a  in  15  CPU byte address within the window
- cpu_wdata  in  8  write data, sampled at grant
- cpu_rdata  out  8  last CPU read data, held until the next CPU read completes
- cpu_overrun  out  1  sticky; a second rising edge of cpu_req arrived while one was still pending
- dma_req  in  1  level; held high until dma_ack
- dma_we  in  1  1 = write
- dma_addr  in  19  byte address
- dma_wdata  in  8  write data
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  8  DMA read data, valid with dma_ack, held until the next DMA read
- busy  out  1  high when the FSM is not IDLE
- SRAM_ADDR  out  18  word address = byte address[18:1]
- SRAM_DQ_in  in  16  pad input
- SRAM_DQ_out  out  16  pad output, {wdata, wdata}
- SRAM_DQ_oe  out  1  pad output enable
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes

## Operation
- **CPU byte address:** {cpu_page, cpu_a}. Byte address bit 0 = 0 selects the LB lane (DQ[7:0]); bit 0 = 1 selects the UB lane (DQ[15:8]).
- **CPU edge detection:** a registered copy of cpu_req detects a rising edge, which sets cpu_pending.
  - cpu_pending clears when the CPU access is granted.
  - If another rising edge arrives while cpu_pending is set, the two requests merge into one access and cpu_overrun is set.
- **FSM states:** IDLE, ACCESS, RECOVER. Registered context: owner (CPU/DMA), we, address, wdata, lane.
  - IDLE: if cpu_pending, grant the CPU. Else if dma_req, grant DMA. Else stay. On grant, latch the context and go to ACCESS.
  - ACCESS: lasts ACC_CYCLES cycles, counted by a down-counter.
    - CE_N=0, the selected lane enable is 0, the other lane is 1, SRAM_ADDR is stable.
    - Read: OE_N=0. SRAM_DQ_in is latched on the clock edge ending the last ACCESS cycle, into cpu_rdata or dma_rdata by owner.
    - Write: SRAM_DQ_oe=1, WE_N=0.
  - RECOVER: 1 cycle. OE_N=1, WE_N=1, CE_N and address held. For writes, DQ_oe stays 1 (data hold). dma_ack=1 if owner is DMA. Then go to IDLE.
- **Idle outputs:** in IDLE all strobes are 1 and DQ_oe=0.
- **Back-to-back DMA:** if dma_req stays high after ack, it is a new request and is arbitrated at the next IDLE. The CPU still wins if pending.

## Timing
- **Reset values** (applied asynchronously, even mid-access): CE_N/OE_N/WE_N/UB_N/LB_N=1, DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0, cpu_rdata=0, dma_rdata=0, dma_ack=0, cpu_overrun=0, busy=0, cpu_pending=0, state=IDLE. No ack is issued for an aborted access.
- **Slot period:** IDLE + ACC_CYCLES + RECOVER = ACC_CYCLES+2 cycles per access.
- **CPU read latency, best case:** cpu_req edge sampled in cycle 0 → grant in cycle 1 → cpu_rdata valid from cycle ACC_CYCLES+2.
- **CPU read latency, worst case:** a DMA grant happens in cycle 0, giving ACC_CYCLES*2+3. The integrator must size clk_vram so this fits within the Z80 read window.
- **Simultaneous CPU edge and dma_req in IDLE:** the CPU is granted first and DMA is granted at the following IDLE.
- **CPU edge during a DMA access:** the DMA access completes and acks normally, and the CPU is granted at the next IDLE.
- **dma_req dropped before ack:** not allowed; the behaviour is undefined.
- **WE_N timing:** WE_N rises one cycle before DQ_oe falls. OE_N and WE_N are never low in the same cycle.

## Test plan
- **CPU read:** ACC_CYCLES=2; SRAM word 0x0040 = 0xBEEF; cpu_page=0, cpu_a=0x0081, cpu_req rises in cycle 0 → OE_N low in cycles 2–3, UB_N=0, LB_N=1; cpu_rdata=0xBE from cycle 4.
- **DMA write then read back:** write addr 0x12345 with 0x5A → exactly one dma_ack, WE_N low for 2 cycles, SRAM_ADDR=0x091A2, UB_N=0. A DMA read of the same address → dma_rdata=0x5A together with dma_ack.
- **Priority:** cpu_req edge and dma_req rise in the same cycle → the CPU access completes first; dma_ack follows 4 cycles after the CPU slot; no overrun.
- **Worst-case latency:** DMA granted in cycle 0 and cpu_req edge sampled in cycle 0 → cpu_rdata valid in cycle 7; dma_ack in cycle 3.
- **Overrun:** two cpu_req rising edges occur while the first is still pending → cpu_overrun=1 and stays 1 until nreset; only one SRAM access occurs.
- **Reset mid-write:** nreset asserted while WE_N=0 → WE_N=1, DQ_oe=0 and all strobes inactive immediately; no dma_ack; after release, the FSM is in IDLE and busy=0.
